int_ctrl8: RTL
==============

Name: int_ctrl8

Overview:
- 8-source interrupt controller for the Citrus CPU.
- Synchronises eight active-low interrupt lines and latches pending requests. Applies a software mask, resolves the highest-index source with an 8-to-3 priority encoder, and runs an irq/ack/eoi handshake with the core.
- No nesting: one interrupt is in service at a time.

Parameters:
- EDGE_TRIG, 1: 1 = falling-edge latched pending; 0 = level-sensitive pending.
- ACK_TIMEOUT, 255: cycles in REQ without ack before abort; 0 disables the timeout. Counter width is 8 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- int_n  in  8  interrupt sources, active low, asynchronous to clk
- mask_we  in  1  load mask register
- mask_wdata  in  8  new mask; 1 = source masked
- ack  in  1  core accepts current vector, single-cycle pulse
- eoi  in  1  core finished service, single-cycle pulse
- irq  out  1  interrupt request to core
- vector  out  3  index of requested or in-service source
- mask  out  8  current mask register
- pending  out  8  pending register
- in_service  out  8  one-hot in-service source, 0 when idle
- ack_timeout  out  1  one-cycle pulse on REQ abort

Behaviour:
- Reset values (async, any state):
  - sync stages and previous-sample register = 8'hFF
  - pending = 0, mask = 8'hFF, in_service = 0
  - vector = 0, irq = 0, ack_timeout = 0
  - state = IDLE, timeout counter = 0
- Input path: two-flop synchroniser per bit (s1, s2), plus previous-sample register p.
- Pending, edge mode: pending[i] is set when p[i]=1 and s2[i]=0. It is cleared when ack grants source i. Set and clear on the same cycle: set wins.
- Pending, level mode: pending <= ~s2 every cycle. Ack has no effect on pending.
- Mask: mask_we loads mask_wdata at the clock edge; the new mask is used from the next cycle. Masking never clears pending.
- Priority: eligible = pending & ~mask. Highest set index wins, so source 7 has top priority. elig_any = |eligible.
- Latency: first edge sampling int_n[i] low = E0; s2 captures at E1; pending set at E2; state = REQ and irq = 1 after E3.
- FSM:
  - IDLE:
    - irq = 0, in_service = 0.
    - If elig_any: go to REQ, vector <= enc(eligible), counter <= 0.
  - REQ:
    - irq = 1; vector re-registers enc(eligible) every cycle, so a later higher-priority arrival replaces it before ack.
    - ack=1: in_service <= one-hot(vector), clear pending[vector] (edge mode), go to SERVICE, irq = 0 from the next cycle. The vector presented in the ack cycle is the granted one.
    - Without ack, if elig_any = 0 (source masked or level dropped): go to IDLE, no error.
    - Without ack, if ACK_TIMEOUT != 0 and counter == ACK_TIMEOUT-1: go to IDLE, ack_timeout pulses 1 cycle, pending untouched.
    - Otherwise counter increments.
  - SERVICE:
    - irq = 0; vector held; new pending requests accumulate.
    - eoi=1: in_service <= 0, go to IDLE.
- Earliest re-request: IDLE at eoi+1, REQ at eoi+2.
- ack outside REQ is ignored; eoi outside SERVICE is ignored. ack and eoi together in REQ: ack wins, eoi is ignored.
- Same source re-edging during SERVICE sets its pending bit again and is served after eoi.
- Reset mid-handshake: immediate return to reset values; any in-flight ack/eoi is lost.
- All outputs are registered or decoded from registered state; there is no combinational path from int_n to any output.

Decomposition:
- Package intc_pkg:
  - NUM_SRC = 8, VEC_W = 3
  - state enum {IDLE, REQ, SERVICE}, 2 bits
  - TO_W = 8
- Sub-module prio_enc8: combinational, active-high 8-bit input. Outputs a 3-bit index of the highest set bit and a valid bit. Instantiated once on eligible.

Test Plan:
- Reset, unmask 8'h00, pull int_n = 8'hFB (source 2) -> pending = 8'h04 after E2, irq = 1 and vector = 2 after E3; ack -> in_service = 8'h04, pending = 0, irq = 0; eoi -> in_service = 0, IDLE.
- Sources 1 and 5 pending, then source 7 asserted before ack -> vector moves 5 -> 7; ack grants 7. Afterwards 5, then 1, are served in order through successive eoi cycles.
- mask = 8'h80 with source 7 pending -> irq stays 0; write mask 8'h00 -> irq rises 2 cycles after the mask_we edge (mask at +1, REQ at +2) with vector = 7.
- ACK_TIMEOUT = 4, source 3 pending, no ack -> irq high exactly 4 cycles, ack_timeout pulses once, IDLE, then REQ again since pending = 8'h08.
- EDGE_TRIG = 0: hold int_n[6] low -> REQ; release before ack -> return to IDLE, no ack_timeout. Assert rst while in SERVICE -> all outputs back to reset values in the same cycle.

Source files
------------

// File: rtl/int_ctrl8_pkg.sv
// intc_pkg: shared constants and types for the int_ctrl8 interrupt controller.
//   NUM_SRC  number of interrupt sources
//   VEC_W    width of a source index
//   TO_W     width of the ack-timeout counter
//   state_e  handshake state (IDLE / REQ / SERVICE)
package intc_pkg;

  localparam int NUM_SRC = 8;
  localparam int VEC_W   = 3;
  localparam int TO_W    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // One-hot decode of a source index.
  function automatic logic [NUM_SRC-1:0] vec2onehot(input logic [VEC_W-1:0] v);
    return NUM_SRC'(1) << v;
  endfunction

endpackage

// File: rtl/int_ctrl8_prio_enc8.sv
// prio_enc8: combinational 8-to-3 priority encoder, highest set index wins.
//   req_i    active-high request vector
//   idx_o    index of the highest set bit (0 when none set)
//   valid_o  at least one request bit is set
module prio_enc8
  import intc_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_i,
  output logic [VEC_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    // Ascending scan: the last hit is the highest index.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req_i[i]) begin
        idx_o = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl8.sv
// int_ctrl8: 8-source interrupt controller with irq/ack/eoi handshake.
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   int_n        interrupt sources, active low, asynchronous to clk
//   mask_we      load mask register from mask_wdata
//   mask_wdata   new mask, 1 = source masked
//   ack          core accepts the presented vector (pulse)
//   eoi          core finished service (pulse)
//   irq          interrupt request to the core
//   vector       index of requested / in-service source
//   mask         current mask register
//   pending      pending register
//   in_service   one-hot in-service source, 0 when idle
//   ack_timeout  one-cycle pulse when a request is aborted for lack of ack
module int_ctrl8
  import intc_pkg::*;
#(
  parameter bit          EDGE_TRIG   = 1'b1,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] int_n,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               ack,
  input  logic               eoi,
  output logic               irq,
  output logic [VEC_W-1:0]   vector,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service,
  output logic               ack_timeout
);

  localparam bit            TO_EN   = (ACK_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic [NUM_SRC-1:0] s1_q, s2_q, p_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] insvc_q, insvc_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic               ato_q, ato_d;
  state_e             state_q, state_d;

  logic [NUM_SRC-1:0] eligible;
  logic [VEC_W-1:0]   enc_idx;
  logic               enc_valid;
  logic               grant;
  logic [NUM_SRC-1:0] grant_clr;

  // Two-flop synchroniser plus one more stage kept as the previous sample,
  // so a falling edge is seen as p=1, s2=0. Idle level of int_n is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '1;
      s2_q <= '1;
      p_q  <= '1;
    end else begin
      s1_q <= int_n;
      s2_q <= s1_q;
      p_q  <= s2_q;
    end
  end

  assign eligible = pend_q & ~mask_q;

  prio_enc8 u_prio_enc8 (
    .req_i   (eligible),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  assign grant_clr = grant ? vec2onehot(vec_q) : '0;

  // Edge mode: a new edge on the same cycle as the grant re-arms the bit.
  always_comb begin
    pend_d = EDGE_TRIG ? ((pend_q & ~grant_clr) | (p_q & ~s2_q)) : ~s2_q;
    mask_d = mask_we ? mask_wdata : mask_q;
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    insvc_d = insvc_q;
    ato_d   = 1'b0;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d = REQ;
          vec_d   = enc_idx;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (ack) begin
          // The vector on the bus during the ack cycle is the one granted.
          grant   = 1'b1;
          insvc_d = vec2onehot(vec_q);
          state_d = SERVICE;
        end else begin
          // Track late higher-priority arrivals until the core accepts.
          if (enc_valid) begin
            vec_d = enc_idx;
          end
          if (!enc_valid) begin
            state_d = IDLE;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            state_d = IDLE;
            ato_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SERVICE: begin
        if (eoi) begin
          insvc_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      mask_q  <= '1;
      insvc_q <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      ato_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      insvc_q <= insvc_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      ato_q   <= ato_d;
      state_q <= state_d;
    end
  end

  assign irq         = (state_q == REQ);
  assign vector      = vec_q;
  assign mask        = mask_q;
  assign pending     = pend_q;
  assign in_service  = insvc_q;
  assign ack_timeout = ato_q;

endmodule
